// File: rtl/adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_arbiter_pkg
//   Shared definitions for the round-robin adder scheduler: default
//   requester count and operand width, plus the scheduler state encoding.
// ---------------------------------------------------------------------------
package adder_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches the eligible requests
//   (req & ~mask) starting one position after ptr and wrapping modulo
//   NUM_REQ; the requester at ptr itself is therefore checked last.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   mask    in   NUM_REQ  requests to exclude from this search
//   ptr     in   IDX_W    index of the most recently served requester
//   winner  out  NUM_REQ  one-hot winner (all zero if none)
//   index   out  IDX_W    binary index of the winner
//   valid   out  1        at least one eligible request
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;

    assign eligible = req & ~mask;

    // Walk the candidates in priority order; the first eligible one wins.
    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && eligible[cand]) begin
                valid         = 1'b1;
                index         = cand;
                winner[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one registered-input adder among NUM_REQ requesters. A winner's
//   operands are latched on the grant edge, presented to the adder with
//   Add_En for exactly one cycle, and the sum is captured one cycle later
//   and returned with a single-cycle Ack. Under continuous load one result
//   is produced every three cycles.
//
// Build option:
//   ADDER_ARB_SAT_EN  when defined, a carry-out at capture saturates Result
//                     to all ones (Result_Ovf still reports 1); otherwise
//                     Result is the wrapped sum.
//
// Ports:
//   Clk         in   1              system clock, rising edge
//   Rst_n       in   1              asynchronous active-low reset
//   Req         in   NUM_REQ        level request per requester
//   Op_A        in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   Op_B        in   NUM_REQ*WIDTH  operand B, same packing
//   Grant       out  NUM_REQ        one-hot requester being served
//   Ack         out  NUM_REQ        one-hot single-cycle result strobe
//   Result      out  WIDTH          registered sum
//   Result_Ovf  out  1              registered carry-out
//   Add_A       out  WIDTH          adder operand A
//   Add_B       out  WIDTH          adder operand B
//   Add_En      out  1              adder input enable
//   Add_Sum     in   WIDTH          adder sum
//   Add_Ovf     in   1              adder carry-out
// ---------------------------------------------------------------------------
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] Op_A,
    input  logic [NUM_REQ*WIDTH-1:0] Op_B,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Ack,
    output logic [WIDTH-1:0]         Result,
    output logic                     Result_Ovf,
    output logic [WIDTH-1:0]         Add_A,
    output logic [WIDTH-1:0]         Add_B,
    output logic                     Add_En,
    input  logic [WIDTH-1:0]         Add_Sum,
    input  logic                     Add_Ovf
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;
    logic               load;
    logic               capture;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // In DONE the pointer register has not yet been updated, so the search
    // starts after the current winner directly, and that winner is masked
    // because its Req may legitimately still be high during the Ack cycle.
    assign pick_ptr  = (state == ST_DONE) ? win_idx : ptr;
    assign pick_mask = (state == ST_DONE) ? Grant : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (Req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .winner (pick_onehot),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    assign sel_a = Op_A[int'(pick_idx)*WIDTH +: WIDTH];
    assign sel_b = Op_B[int'(pick_idx)*WIDTH +: WIDTH];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // load marks a grant edge (from IDLE or back-to-back from DONE);
    // capture marks the edge on which the adder output is registered.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    load       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (pick_valid) begin
                    load       = 1'b1;
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Add_A/Add_B double as the operand holding registers: they are loaded
    // only on a grant edge, so requester operand changes afterwards are
    // ignored. Add_En is high exactly for the ISSUE cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Grant      <= '0;
            Ack        <= '0;
            Add_En     <= 1'b0;
            Add_A      <= '0;
            Add_B      <= '0;
            Result     <= '0;
            Result_Ovf <= 1'b0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            win_idx    <= '0;
        end else begin
            Add_En <= load;
            Ack    <= capture ? Grant : '0;

            if (load) begin
                Grant   <= pick_onehot;
                win_idx <= pick_idx;
                Add_A   <= sel_a;
                Add_B   <= sel_b;
            end else if (state == ST_DONE) begin
                Grant <= '0;
            end

            if (state == ST_DONE) begin
                ptr <= win_idx;
            end

            if (capture) begin
`ifdef ADDER_ARB_SAT_EN
                Result <= Add_Ovf ? '1 : Add_Sum;
`else
                Result <= Add_Sum;
`endif
                Result_Ovf <= Add_Ovf;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
//   Bench for adder_arbiter with a behavioural registered-input adder.
//   A reference model predicts each grant from the request vector and the
//   round-robin rule and queues the expected Ack; a monitor compares every
//   Ack, Grant and Add_En sample against it. Directed scenarios are followed
//   by a randomized phase. Build option ADDER_ARB_SAT_EN is honoured.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    logic                     Clk   = 1'b0;
    logic                     Rst_n = 1'b0;
    logic [NUM_REQ-1:0]       Req   = '0;
    logic [NUM_REQ*WIDTH-1:0] Op_A  = '0;
    logic [NUM_REQ*WIDTH-1:0] Op_B  = '0;
    logic [NUM_REQ-1:0]       Grant;
    logic [NUM_REQ-1:0]       Ack;
    logic [WIDTH-1:0]         Result;
    logic                     Result_Ovf;
    logic [WIDTH-1:0]         Add_A;
    logic [WIDTH-1:0]         Add_B;
    logic                     Add_En;
    logic [WIDTH-1:0]         Add_Sum;
    logic                     Add_Ovf;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    adder_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req        (Req),
        .Op_A       (Op_A),
        .Op_B       (Op_B),
        .Grant      (Grant),
        .Ack        (Ack),
        .Result     (Result),
        .Result_Ovf (Result_Ovf),
        .Add_A      (Add_A),
        .Add_B      (Add_B),
        .Add_En     (Add_En),
        .Add_Sum    (Add_Sum),
        .Add_Ovf    (Add_Ovf)
    );

    // Registered-input adder: inputs captured when En is high.
    logic [WIDTH-1:0] adder_a = '0;
    logic [WIDTH-1:0] adder_b = '0;
    always @(posedge Clk) begin
        if (Add_En) begin
            adder_a <= Add_A;
            adder_b <= Add_B;
        end
    end
    assign {Add_Ovf, Add_Sum} = {1'b0, adder_a} + {1'b0, adder_b};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Returns {ovf, result} for one request.
    function automatic logic [WIDTH:0] expectedResult(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_SAT_EN
        if (s[WIDTH]) s[WIDTH-1:0] = '1;
`endif
        return s;
    endfunction

    // ----------------------------------------------------------------------
    // Reference model: a grant may happen once the previous job has had
    // three cycles; at exactly three cycles (back-to-back) the previous
    // winner is not eligible. The search starts after the last winner.
    // ----------------------------------------------------------------------
    typedef struct {
        int             idx;
        logic [WIDTH-1:0] res;
        logic           ovf;
        int             ack_cyc;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   last_w = NUM_REQ - 1;
    int   cur_w  = 0;
    int   cur_g  = -100;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            expq.delete();
            last_w = NUM_REQ - 1;
            cur_g  = -100;
        end else begin
            cyc++;
            if (cyc >= cur_g + 3) begin
                int             w;
                logic [WIDTH:0] s;
                exp_t           e;
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int j;
                    j = (last_w + k) % NUM_REQ;
                    if (w < 0 && Req[j] && !(cyc == cur_g + 3 && j == cur_w)) w = j;
                end
                if (w >= 0) begin
                    s         = expectedResult(Op_A[w*WIDTH +: WIDTH], Op_B[w*WIDTH +: WIDTH]);
                    e.idx     = w;
                    e.res     = s[WIDTH-1:0];
                    e.ovf     = s[WIDTH];
                    e.ack_cyc = cyc + 2;
                    expq.push_back(e);
                    cur_w  = w;
                    cur_g  = cyc;
                    last_w = w;
                end
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge Clk) begin
        #1;
        if (Rst_n) begin
            logic [NUM_REQ-1:0] exp_grant;
            logic [NUM_REQ-1:0] exp_ack;
            exp_grant = '0;
            exp_ack   = '0;
            if (cyc <= cur_g + 2) exp_grant[cur_w] = 1'b1;
            checkOutput("grant", Grant, exp_grant);
            checkOutput("add_en", Add_En, (cyc == cur_g));
            if (Ack != '0) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_ack", Ack, exp_ack);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    exp_ack[e.idx] = 1'b1;
                    checkOutput("ack_vector", Ack, exp_ack);
                    checkOutput("ack_cycle", cyc, e.ack_cyc);
                    checkOutput("result", Result, e.res);
                    checkOutput("result_ovf", Result_Ovf, e.ovf);
                end
            end else if (expq.size() != 0 && expq[0].ack_cyc < cyc) begin
                exp_t e;
                e = expq.pop_front();
                exp_ack[e.idx] = 1'b1;
                checkOutput("missing_ack", Ack, exp_ack);
            end
        end
    end

    // ----------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ----------------------------------------------------------------------
    task automatic applyStimulus(input int i, input int a, input int b);
        Op_A[i*WIDTH +: WIDTH] = WIDTH'(a);
        Op_B[i*WIDTH +: WIDTH] = WIDTH'(b);
        Req[i]                 = 1'b1;
    endtask

    task automatic waitAck(input int i, input string name);
        logic [NUM_REQ-1:0] want;
        bit                 seen;
        want    = '0;
        want[i] = 1'b1;
        seen    = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge Clk);
            if (Ack[i]) seen = 1'b1;
        end
        if (!seen) checkOutput({name, "_timeout"}, Ack, want);
    endtask

    task automatic pulseReset();
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, Grant, 0);
        checkOutput({tag, "_ack"}, Ack, 0);
        checkOutput({tag, "_add_en"}, Add_En, 0);
        checkOutput({tag, "_add_a"}, Add_A, 0);
        checkOutput({tag, "_add_b"}, Add_B, 0);
        checkOutput({tag, "_result"}, Result, 0);
        checkOutput({tag, "_result_ovf"}, Result_Ovf, 0);
    endtask

    initial begin
        int                 order[$];
        int                 ack_times[$];
        logic [NUM_REQ-1:0] pend;

        // Reset state
        repeat (3) @(negedge Clk);
        checkAllZero("reset");
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single request 3+4
        applyStimulus(0, 3, 4);
        waitAck(0, "single");
        checkOutput("single_result", Result, 7);
        checkOutput("single_ovf", Result_Ovf, 0);
        Req[0] = 1'b0;
        repeat (2) @(negedge Clk);

        // Overflow 9+9
        applyStimulus(2, 9, 9);
        waitAck(2, "ovf");
`ifdef ADDER_ARB_SAT_EN
        checkOutput("ovf_result", Result, 15);
`else
        checkOutput("ovf_result", Result, 2);
`endif
        checkOutput("ovf_flag", Result_Ovf, 1);
        Req[2] = 1'b0;
        repeat (2) @(negedge Clk);

        // All requesters held continuously from a fresh pointer
        pulseReset();
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, i + 1, 2*i + 3);
        order.delete();
        ack_times.delete();
        for (int n = 0; n < 30 && order.size() < 5; n++) begin
            @(negedge Clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (Ack[i]) begin
                    order.push_back(i);
                    ack_times.push_back(cyc);
                end
            end
        end
        Req = '0;
        checkOutput("rr_count", order.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) checkOutput("rr_order", order[k], k % NUM_REQ);
        for (int k = 1; k < 5; k++)
            if (k < ack_times.size()) checkOutput("rr_spacing", ack_times[k] - ack_times[k-1], 3);
        repeat (3) @(negedge Clk);

        // Operand change after grant is ignored
        applyStimulus(1, 5, 5);
        @(negedge Clk);
        Op_A[1*WIDTH +: WIDTH] = 4'd15;
        waitAck(1, "opchg");
        checkOutput("opchg_result", Result, 10);
        checkOutput("opchg_ovf", Result_Ovf, 0);
        Req[1] = 1'b0;
        repeat (2) @(negedge Clk);

        // Req[3] dropped during ISSUE, Req[0] raised meanwhile
        applyStimulus(3, 6, 7);
        @(negedge Clk);
        Req[3] = 1'b0;
        applyStimulus(0, 2, 8);
        order.delete();
        for (int n = 0; n < 20 && order.size() < 2; n++) begin
            @(negedge Clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (Ack[i]) begin
                    order.push_back(i);
                    Req[i] = 1'b0;
                end
            end
        end
        checkOutput("drop_count", order.size(), 2);
        if (order.size() > 0) checkOutput("drop_first", order[0], 3);
        if (order.size() > 1) checkOutput("drop_second", order[1], 0);
        repeat (2) @(negedge Clk);

        // Reset pulsed during CAPTURE
        applyStimulus(1, 7, 6);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        Req = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        applyStimulus(0, 11, 3);
        applyStimulus(1, 4, 4);
        waitAck(0, "post_reset");
        checkOutput("post_reset_result", Result, 14);
        checkOutput("post_reset_ovf", Result_Ovf, 0);
        Req[0] = 1'b0;
        waitAck(1, "post_reset_second");
        checkOutput("post_reset_second_result", Result, 8);
        Req[1] = 1'b0;
        repeat (2) @(negedge Clk);

        // Randomized traffic; pending operands may change until granted
        pend = '0;
        for (int n = 0; n < 600; n++) begin
            @(negedge Clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (Ack[i]) begin
                    Req[i]  = 1'b0;
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    applyStimulus(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                    pend[i] = 1'b1;
                end else if (pend[i] && $urandom_range(0, 3) == 0) begin
                    Op_A[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
                end
            end
        end
        Req = '0;
        repeat (12) @(negedge Clk);
        checkOutput("drain_queue", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
